layer_serializer: RTL and testbench
===================================

LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30: number of words in one parallel layer output vector (min 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of one neuron output word.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of drop counter.
REQ-004 s_axi_aclk  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  single-cycle strobe; in_data holds a full layer vector.
REQ-007 in_data  in  NUM_NEURONS*DATA_WIDTH  vector; word k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_ready  out  1  high when pending slot is empty; advisory only, in_valid may arrive regardless.
REQ-009 out_data  out  DATA_WIDTH  current serial word.
REQ-010 out_valid  out  1  out_data valid.
REQ-011 out_ready  in  1  downstream accepts beat.
REQ-012 out_last  out  1  high with final word (index NUM_NEURONS-1) of a vector.
REQ-013 out_index  out  $clog2(NUM_NEURONS)  neuron index of current out_data.
REQ-014 overflow  out  1  sticky; a vector was dropped.
REQ-015 drop_count  out  CNT_WIDTH  vectors dropped, saturating.

Function
REQ-016 SHALL hold two vector buffers: active (being sent) and pending (one-deep queue).
REQ-017 SHALL implement states IDLE and SEND; beat = out_valid && out_ready.
REQ-018 IDLE + in_valid: in_data -> active, index 0, go to SEND, out_valid=1 next cycle (latency 1).
REQ-019 SEND: out_data = active word out_index, LSB word first; out_index increments on each beat.
REQ-020 out_data, out_index, out_last SHALL stay stable while out_valid && !out_ready.
REQ-021 Exactly NUM_NEURONS beats per vector; out_last high only when out_index == NUM_NEURONS-1.
REQ-022 SEND + in_valid, not final beat: pending empty -> in_data -> pending; pending full -> drop in_data, overflow=1, drop_count+1.
REQ-023 Final beat, pending full: pending -> active, index 0, stay SEND, no out_valid bubble; concurrent in_valid -> pending (not dropped).
REQ-024 Final beat, pending empty, in_valid same cycle: in_data -> active, index 0, stay SEND, no bubble.
REQ-025 Final beat, pending empty, no in_valid: go to IDLE; out_valid=0, out_last=0 next cycle.
REQ-026 drop_count SHALL saturate at 2^CNT_WIDTH-1; overflow clears only on reset.
REQ-027 in_ready = !pending_full, from registered state.

Reset
REQ-028 reset SHALL force next cycle: state IDLE, out_valid=0, out_last=0, out_data=0, out_index=0, overflow=0, drop_count=0, pending empty, in_ready=1.
REQ-029 reset mid-vector SHALL discard active and pending contents; no further beats of either.
REQ-030 reset SHALL take priority over in_valid in the same cycle (vector not captured).

Verification (NUM_NEURONS=4, DATA_WIDTH=8)
REQ-031 in_data=0x44332211 pulsed cycle N, out_ready=1 -> out_data 11,22,33,44 at N+1..N+4, out_index 0..3, out_last at N+4 only, out_valid=0 at N+5.
REQ-032 Same vector, out_ready low 3 cycles at index 1 -> out_data holds 0x22, out_index 1 for 3 cycles; 4 beats total.
REQ-033 0x44332211 then 0x88776655 at beat 2, out_ready=1 -> 8 contiguous beats 11..44,55..88, out_last twice, no gap.
REQ-034 out_ready=0, three vectors pulsed during SEND -> third dropped; overflow=1, drop_count=1, in_ready=0; after release, only first two vectors output.
REQ-035 in_valid on final beat with pending empty -> next cycle out_data = word 0 of new vector, out_valid stays 1.
REQ-036 reset at index 2 -> next cycle out_valid=0, overflow=0, drop_count=0, in_ready=1; new vector restarts at index 0.

Source files
------------

// File: rtl/layer_serializer.sv
// Serializes one parallel layer output vector into NUM_NEURONS words, LSB word first.
// A one-deep pending slot absorbs a vector arriving mid-send; further arrivals are dropped and counted.
module layer_serializer #(
    parameter  int NUM_NEURONS = 30,
    parameter  int DATA_WIDTH  = 16,
    parameter  int CNT_WIDTH   = 8,
    localparam int IDX_WIDTH   = $clog2(NUM_NEURONS),
    localparam int VEC_WIDTH   = NUM_NEURONS * DATA_WIDTH
) (
    input  logic                  s_axi_aclk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [VEC_WIDTH-1:0]  in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  o_dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    // Handshake: a beat is transferred on every rising edge where out_valid && out_ready;
    // in_valid is a single-cycle strobe that is never back-pressured (in_ready is advisory).
    state_t                 r_state;
    logic [VEC_WIDTH-1:0]   r_active;
    logic [VEC_WIDTH-1:0]   r_pending;
    logic                   r_pend_full;
    logic [IDX_WIDTH-1:0]   r_index;
    logic                   r_out_valid;
    logic                   r_overflow;
    logic [CNT_WIDTH-1:0]   r_drop_count;

    logic                   w_beat;
    logic                   w_at_last;
    logic [VEC_WIDTH-1:0]   w_shifted;

    assign w_beat    = r_out_valid && out_ready;
    assign w_at_last = (r_index == LAST_IDX);
    assign w_shifted = r_active >> (r_index * DATA_WIDTH);

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_full  <= 1'b0;
            r_index      <= '0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_active    <= in_data;
                        r_index     <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_beat && w_at_last) begin
                        // Final beat: refill from pending, else from a coincident input, else go idle.
                        r_index <= '0;
                        if (r_pend_full) begin
                            r_active <= r_pending;
                            if (in_valid) begin
                                r_pending <= in_data;
                            end else begin
                                r_pend_full <= 1'b0;
                            end
                        end else if (in_valid) begin
                            r_active <= in_data;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        if (w_beat) begin
                            r_index <= r_index + IDX_WIDTH'(1);
                        end
                        if (in_valid) begin
                            if (!r_pend_full) begin
                                r_pending   <= in_data;
                                r_pend_full <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                                if (r_drop_count != '1) begin
                                    r_drop_count <= r_drop_count + CNT_WIDTH'(1);
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = !r_pend_full;
    assign out_data    = w_shifted[DATA_WIDTH-1:0];
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_valid && w_at_last;
    assign out_index   = r_index;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer with 4 words of 8 bits and a 2-bit drop counter.
// Expected beats {last, index, data} are queued when vectors are driven and popped on each beat.
module tb_layer_serializer;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int IW  = 2;
  localparam int EW  = 1 + IW + DW;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [N*DW-1:0] in_data;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [IW-1:0]   out_index;
  logic            overflow;
  logic [CW-1:0]   drop_count;
  logic            dbg_state;

  logic [EW-1:0]   exp_q[$];
  int              n_checks;
  int              n_fail;

  layer_serializer #(
    .NUM_NEURONS(N),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .s_axi_aclk (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_index  (out_index),
    .overflow   (overflow),
    .drop_count (drop_count),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock cycle; the beat about to be accepted is scored at the falling edge
  task automatic step();
    logic [EW-1:0] exp;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat got last=%0b idx=%0d data=%h expected none", out_last, out_index, out_data);
      end else begin
        exp = exp_q.pop_front();
        if ({out_last, out_index, out_data} !== exp)
          begin
            n_fail++;
            $display("FAIL beat got last=%0b idx=%0d data=%h expected last=%0b idx=%0d data=%h",
                     out_last, out_index, out_data, exp[EW-1], exp[DW+IW-1:DW], exp[DW-1:0]);
          end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [N*DW-1:0] vec);
    for (int k = 0; k < N; k++) begin
      logic [IW-1:0] kk;
      kk = IW'(k);
      exp_q.push_back({(k == N - 1), kk, vec[k*DW +: DW]});
    end
  endtask

  task automatic pulse(input logic [N*DW-1:0] vec);
    in_valid = 1'b1;
    in_data  = vec;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain_and_check(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) step();
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got out_valid=%0b pending_beats=%0d expected out_valid=0 pending_beats=0",
               name, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if ({out_valid, out_last, out_data, out_index, overflow, drop_count, in_ready, dbg_state} !==
        {1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got v=%0b l=%0b d=%h i=%0d ov=%0b dc=%0d rdy=%0b st=%0b expected v=0 l=0 d=00 i=0 ov=0 dc=0 rdy=1 st=0",
               out_valid, out_last, out_data, out_index, overflow, drop_count, in_ready, dbg_state);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push_vec(32'h44332211);
    pulse(32'h44332211);
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd0 || out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL single_latency got v=%0b i=%0d d=%h expected v=1 i=0 d=11", out_valid, out_index, out_data);
    end
    drain_and_check(4, "single");
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    push_vec(32'h44332211);
    pulse(32'h44332211);
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_index !== 2'd1 || out_data !== 8'h22 || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cycle=%0d got v=%0b i=%0d d=%h l=%0b expected v=1 i=1 d=22 l=0",
                 c, out_valid, out_index, out_data, out_last);
      end
    end
    out_ready = 1'b1;
    drain_and_check(3, "stall");
  endtask

  task automatic test_back_to_back();
    int gaps;
    out_ready = 1'b1;
    push_vec(32'h44332211);
    pulse(32'h44332211);
    step();
    step();
    push_vec(32'h88776655);
    pulse(32'h88776655);
    gaps = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1) gaps++;
      step();
    end
    n_checks++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL back_to_back_gap got gaps=%0d expected gaps=0", gaps);
    end
    drain_and_check(0, "back_to_back");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    push_vec(32'h44332211);
    pulse(32'h44332211);
    push_vec(32'h88776655);
    pulse(32'h88776655);
    pulse(32'hCCBBAA99);
    n_checks++;
    if (overflow !== 1'b1 || drop_count !== 2'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_flags got ov=%0b dc=%0d rdy=%0b expected ov=1 dc=1 rdy=0", overflow, drop_count, in_ready);
    end
    out_ready = 1'b1;
    drain_and_check(8, "overflow");
    n_checks++;
    if (in_ready !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky got rdy=%0b ov=%0b expected rdy=1 ov=1", in_ready, overflow);
    end
  endtask

  task automatic test_saturate();
    logic [N*DW-1:0] v;
    out_ready = 1'b0;
    push_vec(32'h04030201);
    pulse(32'h04030201);
    push_vec(32'h08070605);
    pulse(32'h08070605);
    for (int d = 0; d < 4; d++) begin
      v = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
      pulse(v);
    end
    n_checks++;
    if (drop_count !== 2'd3 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_saturate got dc=%0d ov=%0b expected dc=3 ov=1", drop_count, overflow);
    end
    out_ready = 1'b1;
    drain_and_check(8, "saturate");
  endtask

  task automatic test_final_beat_refill();
    out_ready = 1'b1;
    push_vec(32'hD4C3B2A1);
    pulse(32'hD4C3B2A1);
    step();
    step();
    step();
    push_vec(32'h1F2E3D4C);
    pulse(32'h1F2E3D4C);
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd0 || out_data !== 8'h4C) begin
      n_fail++;
      $display("FAIL final_refill got v=%0b i=%0d d=%h expected v=1 i=0 d=4c", out_valid, out_index, out_data);
    end
    drain_and_check(4, "final_refill");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    push_vec(32'h44332211);
    pulse(32'h44332211);
    step();
    step();
    out_ready = 1'b0;
    pulse(32'h88776655);
    pulse(32'hCCBBAA99);
    exp_q.delete();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hEEEEEEEE;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0 || drop_count !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid got v=%0b l=%0b ov=%0b dc=%0d rdy=%0b expected v=0 l=0 ov=0 dc=0 rdy=1",
               out_valid, out_last, overflow, drop_count, in_ready);
    end
    out_ready = 1'b1;
    drain_and_check(6, "reset_flush");
    push_vec(32'h5A6B7C8D);
    pulse(32'h5A6B7C8D);
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd0 || out_data !== 8'h8D) begin
      n_fail++;
      $display("FAIL reset_restart got v=%0b i=%0d d=%h expected v=1 i=0 d=8d", out_valid, out_index, out_data);
    end
    drain_and_check(4, "reset_restart");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_saturate();
    test_final_beat_refill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
